// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: op encodings, controller FSM state encodings and
// the LO value written on divide by zero.
package mdu_ctrl_pkg;

   localparam int MDU_XLEN = 32;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_t;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [MDU_XLEN-1:0] MDU_DIV0_LO = '1;

endpackage

// File: rtl/div_radix2.sv
// Unsigned restoring radix-2 divider: start_i loads the operands, each step_i
// cycle retires one quotient bit; valid_o marks the final step.
module div_radix2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             valid_o
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};
      count_d = count_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      if (start_i) begin
         count_d = '0;
         rem_d   = '0;
         quo_d   = dividend_i;
         dvs_d   = divisor_i;
      end else if (step_i) begin
         count_d = count_q + CW'(1);
         // A borrow out of the top bit means the divisor did not fit: restore.
         if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
      end else begin
         count_q <= count_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
      end
   end

   // Final iteration is in flight; the result registers hold the answer from the next cycle.
   assign valid_o     = step_i && (count_q == CW'(WIDTH - 1));
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide controller: sole HI/LO writer, stalls IF..EX during divides.
// Optional MDU_DIV0_FAST_EN: divide by zero skips the iterative divider.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   input  logic             ex_stall_i,
   output logic             mdu_stall_o,
   output logic             busy_o,
   output logic             hi_we_o,
   output logic             lo_we_o,
   output logic [WIDTH-1:0] hi_wdata_o,
   output logic [WIDTH-1:0] lo_wdata_o
);

   mdu_op_t op;
   logic    wr_ok;
   logic    div_signed;
   logic    mul_signed;

   logic [1:0]       state_q, state_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             div0_q, div0_d;
   logic [WIDTH-1:0] a_q, a_d;

   logic [2*WIDTH-1:0] ext_a, ext_b, prod;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
   logic               div_start, div_valid;

   logic             stall, hi_we, lo_we;
   logic [WIDTH-1:0] hi_wd, lo_wd;

   assign op         = mdu_op_t'(op_i);
   assign wr_ok      = ~flush_i & ~ex_stall_i;
   assign div_signed = (op == MDU_DIV);
   assign mul_signed = (op == MDU_MULT);

   // Sign-extending both operands to 2*WIDTH lets one multiplier serve MULT and MULTU.
   assign ext_a = {{WIDTH{mul_signed & a_i[WIDTH-1]}}, a_i};
   assign ext_b = {{WIDTH{mul_signed & b_i[WIDTH-1]}}, b_i};
   assign prod  = ext_a * ext_b;

   assign a_abs = (div_signed && a_i[WIDTH-1]) ? -a_i : a_i;
   assign b_abs = (div_signed && b_i[WIDTH-1]) ? -b_i : b_i;

   div_radix2 #(.WIDTH(WIDTH)) u_div (
      .clk         (clk),
      .rst         (rst),
      .start_i     (div_start),
      .step_i      (state_q == S_BUSY),
      .dividend_i  (a_abs),
      .divisor_i   (b_abs),
      .quotient_o  (quo),
      .remainder_o (rem),
      .valid_o     (div_valid)
   );

   // Divide by zero returns the raw dividend in HI and all ones in LO.
   assign res_lo = div0_q ? WIDTH'(MDU_DIV0_LO) : (neg_q ? -quo : quo);
   assign res_hi = div0_q ? a_q : (rneg_q ? -rem : rem);

   always_comb begin
      state_d   = state_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      div0_d    = div0_q;
      a_d       = a_q;
      div_start = 1'b0;
      stall     = 1'b0;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      hi_wd     = '0;
      lo_wd     = '0;
      case (state_q)
         S_IDLE: begin
            if (op_valid_i) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     hi_we = wr_ok;
                     lo_we = wr_ok;
                     hi_wd = prod[2*WIDTH-1:WIDTH];
                     lo_wd = prod[WIDTH-1:0];
                  end
                  MDU_MTHI: begin
                     hi_we = wr_ok;
                     hi_wd = a_i;
                  end
                  MDU_MTLO: begin
                     lo_we = wr_ok;
                     lo_wd = a_i;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     if (!flush_i) begin
                        stall     = 1'b1;
                        div_start = 1'b1;
                        neg_d     = div_signed & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rneg_d    = div_signed & a_i[WIDTH-1];
                        div0_d    = (b_i == '0);
                        a_d       = a_i;
                        state_d   = S_BUSY;
`ifdef MDU_DIV0_FAST_EN
                        if (b_i == '0) state_d = S_DONE;
`endif
                     end
                  end
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            stall = 1'b1;
            if (flush_i)        state_d = S_IDLE;
            else if (div_valid) state_d = S_DONE;
         end
         S_DONE: begin
            hi_wd = res_hi;
            lo_wd = res_lo;
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (!ex_stall_i) begin
               hi_we   = 1'b1;
               lo_we   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         div0_q  <= 1'b0;
         a_q     <= '0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         div0_q  <= div0_d;
         a_q     <= a_d;
      end
   end

   // Several outputs decode live inputs in IDLE, so reset gates them directly.
   assign mdu_stall_o = rst & stall;
   assign busy_o      = rst & (state_q != S_IDLE);
   assign hi_we_o     = rst & hi_we;
   assign lo_we_o     = rst & lo_we;
   assign hi_wdata_o  = rst ? hi_wd : '0;
   assign lo_wdata_o  = rst ? lo_wd : '0;

endmodule
